fetch_unit: RTL and testbench

- Instruction fetch stage directly upstream of the fetch→decode FIFO.
- Generates the sequential PC and issues one request at a time to the instruction memory/cache.
- Packs {instr, addr, PC+4} into a 96-bit entry and pushes it into the FIFO, honouring the FIFO's registered push_must_wait feedback.
- Accepts a PC redirect from execute (taken branch/jump) and discards any in-flight fetch.

---
 rtl/fetch_pkg.sv | 31 +++
 rtl/fetch_unit_if.sv | 51 +++++
 rtl/fetch_unit.sv | 134 +++++++++++++
 tb/tb_fetch_unit.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch stage and its consumers.
// Decode imports this package to unpack the 96-bit fetch->decode FIFO entry.
package fetch_pkg;

    // Fetch sequencer states.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        WAIT  = 3'd2,
        PUSH  = 3'd3,
        CHECK = 3'd4
    } fetch_state_t;

    localparam int INSTR_W   = 32;
    localparam int ADDR_W    = 32;
    localparam int ELEM_W    = INSTR_W + 2 * ADDR_W;

    // Field offsets inside a FIFO entry: {instr, addr, addr+4}.
    localparam int INSTR_LSB = 64;
    localparam int ADDR_LSB  = 32;
    localparam int NPC_LSB   = 0;

    // Build a FIFO entry from a fetched word and the address it came from.
    function automatic logic [ELEM_W-1:0] pack_entry(input logic [INSTR_W-1:0] instr,
                                                     input logic [ADDR_W-1:0]  addr);
        logic [ADDR_W-1:0] npc;
        npc = addr + ADDR_W'(4);
        return {instr, addr, npc};
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Bus bundle between the fetch stage and its environment: the instruction
// memory port, the execute redirect port and the fetch->decode FIFO push port.
//
// Handshake semantics:
//   - icache_req is a one-cycle strobe with icache_addr valid in the same
//     cycle; memory answers with exactly one icache_ready pulse (data valid
//     with it) at least one cycle later. No second request is issued before
//     that answer arrives.
//   - redirect_valid is a one-cycle strobe qualifying redirect_pc.
//   - pushing is a one-cycle strobe qualifying out_data; the FIFO answers in
//     the following cycle with push_must_wait=1 if that push was rejected.
interface fetch_unit_if;
    import fetch_pkg::*;

    logic              icache_req;
    logic [ADDR_W-1:0] icache_addr;
    logic              icache_ready;
    logic [INSTR_W-1:0] icache_data;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_pc;
    logic [ELEM_W-1:0] out_data;
    logic              pushing;
    logic              push_must_wait;

    // Fetch stage side.
    modport master (
        output icache_req,
        output icache_addr,
        input  icache_ready,
        input  icache_data,
        input  redirect_valid,
        input  redirect_pc,
        output out_data,
        output pushing,
        input  push_must_wait
    );

    // Memory / execute / FIFO side.
    modport slave (
        input  icache_req,
        input  icache_addr,
        output icache_ready,
        output icache_data,
        output redirect_valid,
        output redirect_pc,
        input  out_data,
        input  pushing,
        output push_must_wait
    );

endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: sequential PC, one outstanding memory request,
// packs {instr, addr, addr+4} into the decode FIFO and retries rejected
// pushes. Execute redirects override everything except reset.
// Optional build macro FETCH_PERF_EN adds saturating perf_fetched/perf_stall
// counters.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC       = 32'hBFC0_0000,
    parameter int          ELEM_SIZE_BITS = 96
) (
    input  logic         CLK,
    input  logic         RESET,
    fetch_unit_if.master bus,
`ifdef FETCH_PERF_EN
    output logic [31:0]  perf_fetched,
    output logic [31:0]  perf_stall,
`endif
    output fetch_state_t dbg_state_o
);

    fetch_state_t              state_q, state_d;
    logic [ADDR_W-1:0]         pc_q, pc_d;
    logic                      drop_q, drop_d;
    logic [ELEM_SIZE_BITS-1:0] data_q, data_d;
    logic [ADDR_W-1:0]         redir_pc;
    logic                      unused_redir_lsbs;

    // Redirect targets are word aligned; the low bits are simply ignored.
    assign redir_pc          = {bus.redirect_pc[31:2], 2'b00};
    assign unused_redir_lsbs = ^bus.redirect_pc[1:0];

    // State and datapath registers.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            drop_q  <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            drop_q  <= drop_d;
            data_q  <= data_d;
        end
    end

    // Next-state logic: normal sequencing first, then the redirect overlay,
    // which takes priority over any normal transition.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        drop_d  = drop_q;
        data_d  = data_q;

        case (state_q)
            IDLE: state_d = REQ;
            REQ:  state_d = WAIT;
            WAIT: begin
                if (bus.icache_ready) begin
                    if (drop_q) begin
                        // Answer to a request made before a redirect: discard.
                        drop_d  = 1'b0;
                        state_d = REQ;
                    end else begin
                        data_d  = pack_entry(bus.icache_data, pc_q);
                        state_d = PUSH;
                    end
                end
            end
            PUSH: state_d = CHECK;
            CHECK: begin
                if (bus.push_must_wait) begin
                    state_d = PUSH;
                end else begin
                    pc_d    = pc_q + ADDR_W'(4);
                    state_d = REQ;
                end
            end
            default: state_d = IDLE;
        endcase

        if (bus.redirect_valid) begin
            pc_d = redir_pc;
            case (state_q)
                REQ: begin
                    // The request just issued will still be answered.
                    drop_d  = 1'b1;
                    state_d = WAIT;
                end
                WAIT: begin
                    data_d = data_q;
                    if (bus.icache_ready) begin
                        drop_d  = 1'b0;
                        state_d = REQ;
                    end else begin
                        drop_d  = 1'b1;
                        state_d = WAIT;
                    end
                end
                default: state_d = REQ;
            endcase
        end
    end

    // Moore outputs decoded from the registered state.
    assign bus.icache_req  = (state_q == REQ);
    assign bus.icache_addr = (state_q == REQ) ? pc_q : '0;
    assign bus.pushing     = (state_q == PUSH);
    assign bus.out_data    = data_q;
    assign dbg_state_o     = state_q;

`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched_q, perf_stall_q;

    // Count accepted and rejected push outcomes, saturating at all-ones.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            perf_fetched_q <= '0;
            perf_stall_q   <= '0;
        end else if (state_q == CHECK) begin
            if (bus.push_must_wait) begin
                if (perf_stall_q != 32'hFFFF_FFFF) perf_stall_q <= perf_stall_q + 32'd1;
            end else begin
                if (perf_fetched_q != 32'hFFFF_FFFF) perf_fetched_q <= perf_fetched_q + 32'd1;
            end
        end
    end

    assign perf_fetched = perf_fetched_q;
    assign perf_stall   = perf_stall_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: a cycle stepper models the instruction memory and
// the FIFO feedback; each scenario task checks DUT outputs against values
// derived from the fetch rules (PC sequence, entry layout, cycle spacing).
module tb_fetch_unit;
    import fetch_pkg::*;

    localparam logic [31:0] RST_PC = 32'hBFC0_0000;

    logic         clk;
    logic         rst;
    fetch_unit_if bus();
    fetch_state_t dbg_state;
`ifdef FETCH_PERF_EN
    logic [31:0]  perf_fetched;
    logic [31:0]  perf_stall;
`endif

    fetch_unit #(.RESET_PC(RST_PC), .ELEM_SIZE_BITS(96)) dut (
        .CLK         (clk),
        .RESET       (rst),
        .bus         (bus),
`ifdef FETCH_PERF_EN
        .perf_fetched(perf_fetched),
        .perf_stall  (perf_stall),
`endif
        .dbg_state_o (dbg_state)
    );

    // Clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    // Environment model state.
    bit          mem_pend;
    int          mem_cnt;
    logic [31:0] mem_data_pend;
    int          mem_lat;
    bit          mem_lat_rand;
    bit          mem_fixed_en;
    logic [31:0] mem_fixed_data;
    bit          rej_pend;
    int          rej_count;
    bit          rej_rand;

    logic [95:0] exp_q[$];

    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hA5A5_0F0F;
    endfunction

    // Advance to the next negedge and play the memory and FIFO roles.
    task automatic step();
        @(negedge clk);
        cyc++;
        bus.icache_ready = 1'b0;
        bus.icache_data  = $urandom;
        if (rst) begin
            mem_pend = 1'b0;
        end else begin
            if (mem_pend) begin
                mem_cnt--;
                if (mem_cnt == 0) begin
                    mem_pend         = 1'b0;
                    bus.icache_ready = 1'b1;
                    bus.icache_data  = mem_data_pend;
                end
            end
            if (bus.icache_req) begin
                mem_pend      = 1'b1;
                mem_cnt       = mem_lat_rand ? int'($urandom_range(1, 4)) : mem_lat;
                mem_data_pend = mem_fixed_en ? mem_fixed_data : mem_fn(bus.icache_addr);
            end
        end
        bus.push_must_wait = rej_pend;
        rej_pend = 1'b0;
        if (bus.pushing && !rst) begin
            if (rej_count > 0) begin
                rej_count--;
                rej_pend = 1'b1;
            end else if (rej_rand) begin
                rej_pend = ($urandom_range(0, 3) == 0);
            end
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        rej_count = 0; rej_rand = 0; rej_pend = 0;
        mem_lat = 1; mem_lat_rand = 0; mem_fixed_en = 0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        n_vec++; if (bus.icache_req !== 1'b0) begin n_err++; $display("FAIL reset_req: got %b want 0", bus.icache_req); end
        n_vec++; if (bus.icache_addr !== 32'h0) begin n_err++; $display("FAIL reset_addr: got %h want 0", bus.icache_addr); end
        n_vec++; if (bus.pushing !== 1'b0) begin n_err++; $display("FAIL reset_push: got %b want 0", bus.pushing); end
        n_vec++; if (bus.out_data !== 96'h0) begin n_err++; $display("FAIL reset_data: got %h want 0", bus.out_data); end
        n_vec++; if (dbg_state !== IDLE) begin n_err++; $display("FAIL reset_state: got %0d want IDLE", dbg_state); end
`ifdef FETCH_PERF_EN
        n_vec++; if (perf_fetched !== 32'h0 || perf_stall !== 32'h0) begin n_err++; $display("FAIL reset_perf: got %h/%h want 0/0", perf_fetched, perf_stall); end
`endif
        rst = 1'b0;
        n_vec++; if (bus.icache_req !== 1'b0) begin n_err++; $display("FAIL first_cycle_req: got %b want 0", bus.icache_req); end
        step();
        n_vec++; if (bus.icache_req !== 1'b1 || bus.icache_addr !== RST_PC) begin n_err++; $display("FAIL second_cycle_req: got %b/%h want 1/%h", bus.icache_req, bus.icache_addr, RST_PC); end
    endtask

    task automatic test_first_fetch();
        do_reset();
        mem_fixed_en = 1; mem_fixed_data = 32'h2408_0005;
        step();
        n_vec++; if (bus.icache_req !== 1'b1 || bus.icache_addr !== 32'hBFC0_0000) begin n_err++; $display("FAIL ff_req: got %b/%h want 1/bfc00000", bus.icache_req, bus.icache_addr); end
        mem_fixed_en = 0;
        step();
        n_vec++; if (bus.icache_req !== 1'b0 || bus.pushing !== 1'b0) begin n_err++; $display("FAIL ff_wait: got req %b push %b want 0/0", bus.icache_req, bus.pushing); end
        step();
        n_vec++; if (bus.pushing !== 1'b1 || bus.out_data !== 96'h24080005_BFC00000_BFC00004) begin n_err++; $display("FAIL ff_push: got %b/%h want 1/24080005bfc00000bfc00004", bus.pushing, bus.out_data); end
        step();
        n_vec++; if (bus.pushing !== 1'b0) begin n_err++; $display("FAIL ff_push_len: got %b want 0", bus.pushing); end
        step();
        n_vec++; if (bus.icache_req !== 1'b1 || bus.icache_addr !== 32'hBFC0_0004) begin n_err++; $display("FAIL ff_next_req: got %b/%h want 1/bfc00004", bus.icache_req, bus.icache_addr); end
    endtask

    task automatic test_sequential();
        int pushes = 0;
        int last = 0;
        logic [31:0] a;
        do_reset();
        for (int i = 0; i < 40 && pushes < 3; i++) begin
            step();
            if (bus.pushing) begin
                a = RST_PC + 32'(4 * pushes);
                n_vec++; if (bus.out_data !== {mem_fn(a), a, a + 32'd4}) begin n_err++; $display("FAIL seq_entry%0d: got %h want %h", pushes, bus.out_data, {mem_fn(a), a, a + 32'd4}); end
                if (pushes > 0) begin
                    n_vec++; if (cyc - last !== 4) begin n_err++; $display("FAIL seq_spacing%0d: got %0d want 4", pushes, cyc - last); end
                end
                last = cyc;
                pushes++;
            end
        end
        n_vec++; if (pushes !== 3) begin n_err++; $display("FAIL seq_count: got %0d want 3", pushes); end
    endtask

    task automatic test_backpressure();
        int pushes = 0;
        int reqs = 0;
        logic [95:0] e;
        e = {mem_fn(RST_PC), RST_PC, RST_PC + 32'd4};
        do_reset();
        rej_count = 2;
        for (int i = 0; i < 40 && pushes < 3; i++) begin
            step();
            if (bus.icache_req) reqs++;
            if (bus.pushing) begin
                pushes++;
                n_vec++; if (bus.out_data !== e) begin n_err++; $display("FAIL bp_entry%0d: got %h want %h", pushes, bus.out_data, e); end
            end
        end
        n_vec++; if (pushes !== 3) begin n_err++; $display("FAIL bp_pushes: got %0d want 3", pushes); end
        n_vec++; if (reqs !== 1) begin n_err++; $display("FAIL bp_reqs: got %0d want 1", reqs); end
        step();
        step();
        n_vec++; if (bus.icache_req !== 1'b1 || bus.icache_addr !== RST_PC + 32'd4) begin n_err++; $display("FAIL bp_next_req: got %b/%h want 1/%h", bus.icache_req, bus.icache_addr, RST_PC + 32'd4); end
`ifdef FETCH_PERF_EN
        n_vec++; if (perf_stall !== 32'd2 || perf_fetched !== 32'd1) begin n_err++; $display("FAIL bp_perf: got %0d/%0d want 2/1", perf_stall, perf_fetched); end
`endif
    endtask

    task automatic test_redirect_wait();
        int base;
        int req_cyc = -1;
        int pushes = 0;
        logic [31:0] t;
        t = 32'h0040_0010;
        do_reset();
        mem_lat = 4; mem_fixed_en = 1; mem_fixed_data = 32'hDEAD_BEEF;
        step();
        n_vec++; if (bus.icache_req !== 1'b1) begin n_err++; $display("FAIL rw_req: got %b want 1", bus.icache_req); end
        mem_fixed_en = 0; mem_lat = 1;
        step();
        bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h0040_0013;
        step();
        bus.redirect_valid = 1'b0;
        base = cyc;
        for (int i = 0; i < 30 && pushes == 0; i++) begin
            if (bus.icache_req && req_cyc < 0) begin
                req_cyc = cyc;
                n_vec++; if (bus.icache_addr !== t) begin n_err++; $display("FAIL rw_addr: got %h want %h", bus.icache_addr, t); end
            end
            if (bus.pushing) begin
                pushes++;
                n_vec++; if (bus.out_data !== {mem_fn(t), t, t + 32'd4}) begin n_err++; $display("FAIL rw_entry: got %h want %h", bus.out_data, {mem_fn(t), t, t + 32'd4}); end
            end
            step();
        end
        n_vec++; if (req_cyc - base !== 3) begin n_err++; $display("FAIL rw_req_time: got %0d want 3", req_cyc - base); end
        n_vec++; if (pushes !== 1) begin n_err++; $display("FAIL rw_timeout: got %0d pushes want 1", pushes); end
    endtask

    task automatic test_redirect_check();
        bit found = 0;
        int pushes = 0;
        logic [31:0] t;
        t = 32'h1234_5678;
        do_reset();
        rej_count = 1;
        for (int i = 0; i < 20 && !found; i++) begin
            step();
            if (bus.pushing) found = 1;
        end
        n_vec++; if (found !== 1'b1) begin n_err++; $display("FAIL rc_first_push: got 0 want 1"); end
        step();
        bus.redirect_valid = 1'b1; bus.redirect_pc = t;
        step();
        bus.redirect_valid = 1'b0;
        n_vec++; if (bus.pushing !== 1'b0) begin n_err++; $display("FAIL rc_no_retry: got %b want 0", bus.pushing); end
        n_vec++; if (bus.icache_req !== 1'b1 || bus.icache_addr !== t) begin n_err++; $display("FAIL rc_req: got %b/%h want 1/%h", bus.icache_req, bus.icache_addr, t); end
`ifdef FETCH_PERF_EN
        n_vec++; if (perf_stall !== 32'd1 || perf_fetched !== 32'd0) begin n_err++; $display("FAIL rc_perf: got %0d/%0d want 1/0", perf_stall, perf_fetched); end
`endif
        for (int i = 0; i < 20 && pushes == 0; i++) begin
            step();
            if (bus.pushing) begin
                pushes++;
                n_vec++; if (bus.out_data !== {mem_fn(t), t, t + 32'd4}) begin n_err++; $display("FAIL rc_entry: got %h want %h", bus.out_data, {mem_fn(t), t, t + 32'd4}); end
            end
        end
        n_vec++; if (pushes !== 1) begin n_err++; $display("FAIL rc_timeout: got %0d pushes want 1", pushes); end
    endtask

    task automatic test_wrap_and_reset();
        bit seen = 0;
        do_reset();
        mem_lat = 3;
        bus.redirect_valid = 1'b1; bus.redirect_pc = 32'hFFFF_FFFF;
        step();
        bus.redirect_valid = 1'b0;
        n_vec++; if (bus.icache_req !== 1'b1 || bus.icache_addr !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL wr_req: got %b/%h want 1/fffffffc", bus.icache_req, bus.icache_addr); end
        for (int i = 0; i < 20 && !seen; i++) begin
            step();
            if (bus.pushing) begin
                seen = 1;
                n_vec++; if (bus.out_data !== {mem_fn(32'hFFFF_FFFC), 32'hFFFF_FFFC, 32'h0}) begin n_err++; $display("FAIL wr_entry: got %h want npc 0", bus.out_data); end
            end
        end
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            step();
            if (bus.icache_req) begin
                seen = 1;
                n_vec++; if (bus.icache_addr !== 32'h0) begin n_err++; $display("FAIL wr_next_addr: got %h want 0", bus.icache_addr); end
            end
        end
        n_vec++; if (seen !== 1'b1) begin n_err++; $display("FAIL wr_timeout: no request after wrap"); end
        step();
        rst = 1'b1;
        step();
        n_vec++; if (dbg_state !== IDLE || bus.pushing !== 1'b0 || bus.icache_req !== 1'b0) begin n_err++; $display("FAIL wr_reset: got state %0d push %b req %b want IDLE/0/0", dbg_state, bus.pushing, bus.icache_req); end
        rst = 1'b0;
        step();
        n_vec++; if (bus.icache_req !== 1'b1 || bus.icache_addr !== RST_PC) begin n_err++; $display("FAIL wr_reset_pc: got %b/%h want 1/%h", bus.icache_req, bus.icache_addr, RST_PC); end
    endtask

    task automatic test_random();
        for (int r = 0; r < 3; r++) begin
            logic [31:0] start;
            logic [31:0] a;
            int accepted = 0;
            int rejected = 0;
            int guard = 0;
            do_reset();
            mem_lat_rand = 1; rej_rand = 1;
            start = $urandom;
            bus.redirect_valid = 1'b1; bus.redirect_pc = start;
            step();
            bus.redirect_valid = 1'b0;
            a = start & 32'hFFFF_FFFC;
            exp_q.delete();
            for (int k = 0; k < 12; k++) begin
                exp_q.push_back({mem_fn(a), a, a + 32'd4});
                a = a + 32'd4;
            end
            while (exp_q.size() > 0 && guard < 1500) begin
                if (bus.icache_req) begin
                    n_vec++; if (bus.icache_addr !== exp_q[0][63:32]) begin n_err++; $display("FAIL rnd_req: got %h want %h", bus.icache_addr, exp_q[0][63:32]); end
                end
                if (bus.pushing) begin
                    n_vec++; if (bus.out_data !== exp_q[0]) begin n_err++; $display("FAIL rnd_entry: got %h want %h", bus.out_data, exp_q[0]); end
                    if (rej_pend) rejected++;
                    else begin
                        void'(exp_q.pop_front());
                        accepted++;
                    end
                end
                if (exp_q.size() > 0) begin
                    step();
                    guard++;
                end
            end
            n_vec++; if (exp_q.size() !== 0) begin n_err++; $display("FAIL rnd_timeout: %0d entries left want 0", exp_q.size()); end
            step();
            step();
`ifdef FETCH_PERF_EN
            n_vec++; if (perf_fetched !== 32'(accepted) || perf_stall !== 32'(rejected)) begin n_err++; $display("FAIL rnd_perf: got %0d/%0d want %0d/%0d", perf_fetched, perf_stall, accepted, rejected); end
`endif
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.icache_ready   = 1'b0;
        bus.icache_data    = '0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.push_must_wait = 1'b0;
        mem_pend = 0; mem_cnt = 0; mem_data_pend = '0;
        mem_lat = 1; mem_lat_rand = 0; mem_fixed_en = 0; mem_fixed_data = '0;
        rej_pend = 0; rej_count = 0; rej_rand = 0;

        test_reset();
        test_first_fetch();
        test_sequential();
        test_backpressure();
        test_redirect_wait();
        test_redirect_check();
        test_wrap_and_reset();
        test_random();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
